// File: rtl/img_pkg.sv
// Shared types and constants for the image engine and its job sequencer.
package img_pkg;

    localparam int IMG_DIM = 64;
    localparam int PIX_W = 8;
    localparam int MODE_W = 2;
    localparam int DEF_TIMEOUT = IMG_DIM * IMG_DIM * 4;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        RUN,
        DONE,
        ERR
    } seq_state_t;

endpackage

// File: rtl/seq_watchdog.sv
// Clear/enable cycle counter with a terminal-count flag at LIMIT-1.
import img_pkg::*;

module seq_watchdog #(
    parameter int LIMIT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/frame_sequencer.sv
// Job-level controller: runs a list of engine passes with reset hold,
// done masking and a per-pass watchdog.
import img_pkg::*;

module frame_sequencer #(
    parameter int MAX_PASSES = 4,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic [2:0]                   num_passes,
    input  logic [MODE_W*MAX_PASSES-1:0] mode_seq,
    input  logic                         proc_done,
    output logic                         proc_reset,
    output logic [MODE_W-1:0]            proc_mode,
    output logic                         busy,
    output logic [$clog2(MAX_PASSES)-1:0] pass_idx,
    output logic                         seq_done,
    output logic                         timeout_err,
    output logic [CNT_W-1:0]             job_cycles
);

    localparam int IW = $clog2(MAX_PASSES);
    localparam int NW = $clog2(MAX_PASSES + 1);

    seq_state_t                  state;
    logic [MODE_W*MAX_PASSES-1:0] modes;
    logic [NW-1:0]               n_pass;
    logic [NW-1:0]               n_clamp;
    logic [IW-1:0]               next_idx;
    logic [MODE_W-1:0]           next_mode;
    logic                        last_pass;
    logic                        first_run;
    logic                        hold_tc;
    logic                        wd_tc;

    assign n_clamp = (int'(num_passes) > MAX_PASSES) ?
                     NW'(MAX_PASSES) : NW'(num_passes);
    assign next_idx = pass_idx + 1'b1;
    assign next_mode = modes[MODE_W*int'(next_idx) +: MODE_W];
    assign last_pass = (int'(pass_idx) == int'(n_pass) - 1);

    seq_watchdog #(.LIMIT(RST_CYCLES)) u_hold (
        .clk  (clk),
        .reset(reset),
        .clear(state != RST),
        .en   (state == RST),
        .tc   (hold_tc)
    );

    seq_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
        .clk  (clk),
        .reset(reset),
        .clear(state != RUN),
        .en   (state == RUN),
        .tc   (wd_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            proc_reset  <= 1'b1;
            proc_mode   <= '0;
            busy        <= 1'b0;
            pass_idx    <= '0;
            seq_done    <= 1'b0;
            timeout_err <= 1'b0;
            job_cycles  <= '0;
            modes       <= '0;
            n_pass      <= '0;
            first_run   <= 1'b0;
        end else begin
            seq_done  <= 1'b0;
            first_run <= 1'b0;
            if ((state == RST || state == RUN) && job_cycles != '1) begin
                job_cycles <= job_cycles + 1'b1;
            end
            if (abort) begin
                state      <= IDLE;
                proc_reset <= 1'b1;
                busy       <= 1'b0;
            end else begin
                unique case (state)
                    IDLE, ERR: begin
                        if (start) begin
                            modes       <= mode_seq;
                            n_pass      <= n_clamp;
                            job_cycles  <= '0;
                            timeout_err <= 1'b0;
                            pass_idx    <= '0;
                            if (n_clamp == '0) begin
                                state    <= DONE;
                                seq_done <= 1'b1;
                            end else begin
                                state     <= RST;
                                proc_mode <= mode_seq[MODE_W-1:0];
                                busy      <= 1'b1;
                            end
                        end
                    end
                    RST: begin
                        if (hold_tc) begin
                            state      <= RUN;
                            proc_reset <= 1'b0;
                            first_run  <= 1'b1;
                        end
                    end
                    RUN: begin
                        // done beats a coincident timeout
                        if (proc_done && !first_run) begin
                            proc_reset <= 1'b1;
                            if (last_pass) begin
                                state    <= DONE;
                                seq_done <= 1'b1;
                                busy     <= 1'b0;
                            end else begin
                                state     <= RST;
                                pass_idx  <= next_idx;
                                proc_mode <= next_mode;
                            end
                        end else if (wd_tc) begin
                            state       <= ERR;
                            timeout_err <= 1'b1;
                            proc_reset  <= 1'b1;
                            busy        <= 1'b0;
                        end
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Randomised job bench for frame_sequencer against a per-job pass model.
module tb_frame_sequencer;

    localparam int TO = 100;
    localparam int RC = 2;
    localparam int MP = 4;
    localparam int CW = 8;

    logic          clk;
    logic          reset;
    logic          start;
    logic          abort;
    logic [2:0]    num_passes;
    logic [7:0]    mode_seq;
    logic          proc_done;
    logic          proc_reset;
    logic [1:0]    proc_mode;
    logic          busy;
    logic [1:0]    pass_idx;
    logic          seq_done;
    logic          timeout_err;
    logic [CW-1:0] job_cycles;

    frame_sequencer #(
        .MAX_PASSES(MP),
        .RST_CYCLES(RC),
        .TIMEOUT_CYCLES(TO),
        .CNT_W(CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .num_passes (num_passes),
        .mode_seq   (mode_seq),
        .proc_done  (proc_done),
        .proc_reset (proc_reset),
        .proc_mode  (proc_mode),
        .busy       (busy),
        .pass_idx   (pass_idx),
        .seq_done   (seq_done),
        .timeout_err(timeout_err),
        .job_cycles (job_cycles)
    );

    int n_assert = 0;
    int n_fail = 0;

    // engine model: done rises lat_cur+1 cycles into a run, or is stuck high
    int lat_cur = 0;
    bit stuck = 0;
    int ecnt = 0;

    // observed pass log
    bit mon_on = 0;
    bit prev_reset = 1;
    int hold_len, run_len, busy_cnt, low_cnt, sd_cnt, mode_glitch;
    logic [1:0] cur_mode;
    int q_mode[$];
    int q_hold[$];
    int q_run[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (proc_reset) ecnt = 0;
        else ecnt++;
        proc_done = stuck || (ecnt > lat_cur);
    end

    always @(negedge clk) begin
        if (mon_on) begin
            if (prev_reset && !proc_reset) begin
                q_mode.push_back(int'(proc_mode));
                q_hold.push_back(hold_len);
                hold_len = 0;
                cur_mode = proc_mode;
            end
            if (!prev_reset && proc_reset) begin
                q_run.push_back(run_len);
                run_len = 0;
            end
            if (busy && proc_reset) hold_len++;
            if (!proc_reset) begin
                run_len++;
                low_cnt++;
                if (proc_mode !== cur_mode) mode_glitch++;
            end
            if (busy) busy_cnt++;
            if (seq_done) sd_cnt++;
            prev_reset = proc_reset;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic run_job(input string tag, input int n,
                           input logic [7:0] ms, input int lat,
                           input bit stk, input bit poke);
        int np, jc, r, k, npass_exp, idx_exp;
        bit to_exp, fin;
        int e_mode[$];
        int e_run[$];
        np = (n > MP) ? MP : n;
        r = stk ? 2 : ((lat + 1 < 2) ? 2 : lat + 1);
        to_exp = (np > 0) && (r > TO);
        if (to_exp) r = TO;
        npass_exp = to_exp ? 1 : np;
        jc = 0;
        for (int p = 0; p < npass_exp; p++) begin
            e_mode.push_back(int'((ms >> (2 * p)) & 8'h3));
            e_run.push_back(r);
            jc += RC + r;
        end
        idx_exp = (to_exp || np == 0) ? 0 : np - 1;

        lat_cur = lat;
        stuck = stk;
        q_mode.delete();
        q_hold.delete();
        q_run.delete();
        hold_len = 0;
        run_len = 0;
        busy_cnt = 0;
        low_cnt = 0;
        sd_cnt = 0;
        mode_glitch = 0;
        prev_reset = proc_reset;
        mon_on = 1;
        num_passes = 3'(n);
        mode_seq = ms;
        start = 1'b1;
        k = 0;
        fin = 0;
        while (!fin && k < 3000) begin
            tick();
            k++;
            if (k == 1) start = 1'b0;
            if (poke) start = (k == 4 || k == 30);
            if (seq_done === 1'b1 || timeout_err === 1'b1) fin = 1;
        end
        start = 1'b0;
        chk({tag, ".finish_latency"}, k, jc + 1);
        chk({tag, ".timeout_err"}, timeout_err, to_exp);
        chk({tag, ".seq_done_now"}, seq_done, !to_exp);
        chk({tag, ".job_cycles"}, job_cycles, (jc > 255) ? 255 : jc);
        chk({tag, ".pass_idx"}, pass_idx, idx_exp);
        tick();
        mon_on = 0;
        chk({tag, ".seq_done_after"}, seq_done, 0);
        chk({tag, ".busy_after"}, busy, 0);
        chk({tag, ".proc_reset_after"}, proc_reset, 1);
        chk({tag, ".seq_done_pulses"}, sd_cnt, to_exp ? 0 : 1);
        chk({tag, ".busy_cycles"}, busy_cnt, jc);
        chk({tag, ".run_cycles"}, low_cnt, jc - RC * npass_exp);
        chk({tag, ".mode_glitch"}, mode_glitch, 0);
        chk({tag, ".passes"}, q_mode.size(), npass_exp);
        chk({tag, ".runs_logged"}, q_run.size(), npass_exp);
        for (int p = 0; p < npass_exp && p < q_mode.size(); p++) begin
            chk($sformatf("%s.mode%0d", tag, p), q_mode[p], e_mode[p]);
            chk($sformatf("%s.hold%0d", tag, p), q_hold[p], RC);
        end
        for (int p = 0; p < npass_exp && p < q_run.size(); p++) begin
            chk($sformatf("%s.run%0d", tag, p), q_run[p], e_run[p]);
        end
    endtask

    initial begin
        int k, jc_hold;
        bit hit;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        num_passes = '0;
        mode_seq = '0;
        repeat (3) tick();
        chk("rst.proc_reset", proc_reset, 1);
        chk("rst.proc_mode", proc_mode, 0);
        chk("rst.busy", busy, 0);
        chk("rst.pass_idx", pass_idx, 0);
        chk("rst.seq_done", seq_done, 0);
        chk("rst.timeout_err", timeout_err, 0);
        chk("rst.job_cycles", job_cycles, 0);
        reset = 1'b0;
        tick();

        run_job("t1", 3, 8'b00_10_01_11, 50, 0, 0);
        chk("t1.job_cycles_159", job_cycles, 159);

        run_job("t2", 0, 8'($urandom), 10, 0, 0);

        run_job("t3", 2, 8'($urandom), 1000, 0, 0);
        repeat (5) tick();
        chk("t3.sticky", timeout_err, 1);
        chk("t3.parked", proc_reset, 1);
        run_job("t3b", 2, 8'($urandom), 10, 0, 0);
        run_job("t3c", 1, 8'($urandom), 1000, 0, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t3c.abort_keeps_err", timeout_err, 1);
        run_job("t3d", 1, 8'($urandom), 5, 0, 0);

        run_job("t4", 7, 8'($urandom), 0, 1, 0);
        stuck = 0;

        // abort during pass 1, with a simultaneous start
        num_passes = 3'd3;
        mode_seq = 8'($urandom);
        lat_cur = 30;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        hit = 0;
        while (!hit && k < 500) begin
            tick();
            k++;
            hit = (pass_idx == 2'd1) && (proc_reset == 1'b0);
        end
        chk("t5.reached_pass1", hit, 1);
        repeat (5) tick();
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("t5.busy", busy, 0);
        chk("t5.proc_reset", proc_reset, 1);
        chk("t5.seq_done", seq_done, 0);
        chk("t5.pass_idx_held", pass_idx, 1);
        jc_hold = int'(job_cycles);
        k = 0;
        hit = 0;
        repeat (10) begin
            tick();
            if (busy || seq_done || !proc_reset) hit = 1;
        end
        chk("t5.stays_idle", hit, 0);
        chk("t5.job_cycles_held", job_cycles, jc_hold);

        run_job("t6", 3, 8'($urandom), 20, 0, 1);

        // synchronous reset in mid-run
        num_passes = 3'd2;
        mode_seq = 8'hff;
        lat_cur = 40;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (proc_reset && k < 50) begin
            tick();
            k++;
        end
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6r.proc_reset", proc_reset, 1);
        chk("t6r.proc_mode", proc_mode, 0);
        chk("t6r.busy", busy, 0);
        chk("t6r.pass_idx", pass_idx, 0);
        chk("t6r.job_cycles", job_cycles, 0);
        chk("t6r.timeout_err", timeout_err, 0);
        tick();
        chk("t6r.still_idle", busy, 0);

        run_job("sat", 4, 8'($urandom), 70, 0, 0);

        for (int i = 0; i < 8; i++) begin
            run_job($sformatf("rnd%0d", i), int'($urandom_range(0, 7)),
                    8'($urandom), int'($urandom_range(0, 70)), 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
Job-level controller for the `process` image engine. It runs a programmed list of up to MAX_PASSES processing passes over the 64x64, 8-bit image held in `image`. For each pass it drives the engine's reset and mode, waits for the engine's done, then advances to the next pass. It also guards each pass with a watchdog and reports job status. It sits between the host/top level and `process`, and replaces the hand-driven reset and mode ties at top level.

Parameters:
MAX_PASSES, 4, maximum passes per job; sizes mode_seq and pass_idx.
RST_CYCLES, 2, minimum cycles proc_reset is held high before every pass.
TIMEOUT_CYCLES, 16384, per-pass watchdog limit in cycles, counted in RUN (64*64*4).
CNT_W, 16, width of the job cycle counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  single-cycle job request; sampled only in IDLE or ERR.
abort  input  1  cancels any job; takes priority over start.
num_passes  input  3  number of passes, 0..7; values above MAX_PASSES are clamped to MAX_PASSES.
mode_seq  input  2*MAX_PASSES  mode of pass k is [2k+1:2k]; latched at start.
proc_done  input  1  done from `process`; level signal.
proc_reset  output  1  reset to `process`; high means the engine is parked.
proc_mode  output  2  mode to `process`; stable for a whole pass.
busy  output  1  high in RST and RUN.
pass_idx  output  2  index of the current pass.
seq_done  output  1  one-cycle pulse when a job completes.
timeout_err  output  1  sticky watchdog error flag.
job_cycles  output  CNT_W  cycles spent in RST+RUN for the last or current job; saturates at all-ones.

Behaviour:
- States: IDLE, RST, RUN, DONE, ERR. All outputs are registered.
- Reset values: state=IDLE, proc_reset=1, proc_mode=0, busy=0, pass_idx=0, seq_done=0, timeout_err=0, job_cycles=0, internal counters=0.
- proc_reset is 1 in every state except RUN. The engine stays parked whenever it is not running.
- IDLE, start=1:
  - latch mode_seq and clamped num_passes (n); clear job_cycles and timeout_err; pass_idx=0.
  - if n=0: go to DONE; proc_reset is never released.
  - else: go to RST with proc_mode=mode_seq[1:0].
- RST: hold for exactly RST_CYCLES cycles, then go to RUN. proc_reset drops on the edge that enters RUN.
- RUN:
  - the watchdog counts from 0 and increments each cycle.
  - proc_done is ignored in the first RUN cycle, to mask stale done from the engine's reset exit.
  - from the second RUN cycle on, proc_done=1 ends the pass:
    - if pass_idx=n-1, go to DONE;
    - else pass_idx+1, proc_mode=next mode, go to RST (proc_reset rises on that edge).
- Watchdog: if it reaches TIMEOUT_CYCLES before done, go to ERR with timeout_err=1.
  - proc_done and the timeout in the same cycle: done wins.
- DONE: seq_done=1 for exactly one cycle, then IDLE. Hold job_cycles and pass_idx.
- ERR:
  - busy=0, timeout_err held.
  - start begins a new job exactly as from IDLE, clearing timeout_err.
  - abort goes to IDLE and keeps timeout_err.
- abort in any state: next state IDLE, proc_reset=1, no seq_done, busy=0. pass_idx and job_cycles are held for debug.
- start while busy (RST/RUN) or in DONE is ignored; no queuing.
- job_cycles increments in RST and RUN only and saturates at 2^CNT_W-1.
- Reset asserted mid-job returns every register to its reset value on the next edge, regardless of state.

Decomposition:
- Shared package img_pkg holds:
  - the seq_state_t enum {IDLE, RST, RUN, DONE, ERR};
  - IMG_DIM=64, PIX_W=8, MODE_W=2;
  - default TIMEOUT_CYCLES derived from IMG_DIM.
- One natural sub-module, seq_watchdog: clear/enable counter with a terminal-count flag, parameterised by limit. The same sub-module is instantiated for the RST hold count.

Test Plan:
1. num_passes=3, mode_seq=8'b00_10_01_11, engine model raises done 50 cycles after reset release -> proc_mode sequence 3,1,2; proc_reset high for exactly 2 cycles before each pass; one seq_done pulse; job_cycles=3*(2+51)=159.
2. num_passes=0 + start -> seq_done one cycle later; proc_reset never low; busy never high.
3. Engine never asserts done, TIMEOUT_CYCLES=100 -> ERR after 100 RUN cycles; timeout_err=1, proc_reset=1, busy=0; then start clears timeout_err and a new job runs.
4. proc_done stuck high across reset release -> first RUN cycle ignored; pass ends on the second RUN cycle; num_passes=7 clamps to 4 passes.
5. abort in RUN of pass 1 -> IDLE next cycle; proc_reset=1; no seq_done; a start asserted on the same cycle as abort is ignored.
6. Synchronous reset in mid-RUN, and start pulsed while busy -> all outputs return to reset values; the busy-time start produces no extra pass.
